// File: rtl/vliw_fetch_pc_pkg.sv
// vliw_pkg: shared bundle geometry helpers, address type and redirect source encoding
//   No ports. BUNDLE_BYTES/ALIGN_BITS derivations, addr_t, trap source code.
package vliw_pkg;
   localparam int ADDR_W_DEF = 32;
   typedef logic [ADDR_W_DEF-1:0] addr_t;
   function automatic int bundle_bytes(int lanes, int inst_bytes);
      return lanes * inst_bytes;
   endfunction
   function automatic int align_bits(int lanes, int inst_bytes);
      return $clog2(lanes * inst_bytes);
   endfunction
   // The trap is encoded one past the last branch lane.
   function automatic int trap_src(int n_br);
      return n_br;
   endfunction
endpackage

// File: rtl/vliw_fetch_pc_if.sv
// vliw_fetch_pc_if: redirect/stall inputs and fetch outputs of the bundle PC
//   master: drives stall, br_taken, br_target, trap, trap_vec; observes pc, squash, misalign, redirect_src
//   slave:  the PC block, the opposite directions
interface vliw_fetch_pc_if #(
   parameter int ADDR_W = 32,
   parameter int N_BR   = 4
);
   logic                           stall;
   logic [N_BR-1:0]                br_taken;
   logic [N_BR-1:0][ADDR_W-1:0]    br_target;
   logic                           trap;
   logic [ADDR_W-1:0]              trap_vec;
   logic [ADDR_W-1:0]              pc;
   logic                           squash;
   logic                           misalign;
   logic [$clog2(N_BR+1)-1:0]      redirect_src;
   modport master (
      output stall, br_taken, br_target, trap, trap_vec,
      input  pc, squash, misalign, redirect_src
   );
   modport slave (
      input  stall, br_taken, br_target, trap, trap_vec,
      output pc, squash, misalign, redirect_src
   );
endinterface

// File: rtl/vliw_fetch_pc_redirect_arbiter.sv
// redirect_arbiter: picks one redirect per cycle, trap over lowest-index taken branch lane
//   in:  br_taken, br_target, trap, trap_vec
//   out: redir_valid, redir_target, redir_src
module redirect_arbiter
   import vliw_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int N_BR   = 4,
   localparam int SRC_W = $clog2(N_BR+1)
) (
   input  logic [N_BR-1:0]             br_taken,
   input  logic [N_BR-1:0][ADDR_W-1:0] br_target,
   input  logic                        trap,
   input  logic [ADDR_W-1:0]           trap_vec,
   output logic                        redir_valid,
   output logic [ADDR_W-1:0]           redir_target,
   output logic [SRC_W-1:0]            redir_src
);
   always_comb begin
      redir_valid  = trap | (|br_taken);
      redir_target = trap_vec;
      redir_src    = SRC_W'(trap_src(N_BR));
      // Scanning downward lets the lowest taken lane overwrite the rest.
      if (!trap)
         for (int i = N_BR - 1; i >= 0; i--)
            if (br_taken[i]) begin
               redir_target = br_target[i];
               redir_src    = SRC_W'(i);
            end
   end
endmodule

// File: rtl/vliw_fetch_pc.sv
// vliw_fetch_pc: bundle program counter with redirect arbitration, alignment and squash window
//   clk, rst_n (async active-low)
//   bus (slave): stall, br_taken, br_target, trap, trap_vec in; pc, squash, misalign, redirect_src out
module vliw_fetch_pc
   import vliw_pkg::*;
#(
   parameter int              ADDR_W        = 32,
   parameter int              LANES         = 4,
   parameter int              INST_BYTES    = 4,
   parameter int              N_BR          = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(32'h0000_0004),
   parameter int              SQUASH_CYCLES = 2
) (
   input logic             clk,
   input logic             rst_n,
   vliw_fetch_pc_if.slave  bus
);
   localparam int BB    = bundle_bytes(LANES, INST_BYTES);
   localparam int AB    = align_bits(LANES, INST_BYTES);
   localparam int CNT_W = $clog2(SQUASH_CYCLES + 1);
   localparam int SRC_W = $clog2(N_BR + 1);
   localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << AB) - 64'd1);
   logic              redir_valid;
   logic [ADDR_W-1:0] redir_target;
   logic [SRC_W-1:0]  redir_src;
   logic [ADDR_W-1:0] pc;
   logic [CNT_W-1:0]  cnt;
   logic              misalign;
   logic [SRC_W-1:0]  src;
   redirect_arbiter #(.ADDR_W(ADDR_W), .N_BR(N_BR)) u_arb (
      .br_taken     (bus.br_taken),
      .br_target    (bus.br_target),
      .trap         (bus.trap),
      .trap_vec     (bus.trap_vec),
      .redir_valid  (redir_valid),
      .redir_target (redir_target),
      .redir_src    (redir_src)
   );
   // The reset vector is loaded as configured; redirect targets are the ones forced onto bundle boundaries.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pc       <= RESET_VEC;
         cnt      <= '0;
         misalign <= 1'b0;
         src      <= '0;
      end else if (redir_valid) begin
         pc       <= redir_target & ~LOW_MASK;
         misalign <= |(redir_target & LOW_MASK);
         src      <= redir_src;
         cnt      <= CNT_W'(SQUASH_CYCLES);
      end else begin
         misalign <= 1'b0;
         if (!bus.stall) begin
            pc  <= pc + ADDR_W'(BB);
            cnt <= cnt - CNT_W'(cnt != '0);
         end
      end
   assign bus.pc           = pc;
   assign bus.squash       = cnt != '0;
   assign bus.misalign     = misalign;
   assign bus.redirect_src = src;
endmodule

// File: tb/tb_vliw_fetch_pc.sv
// tb_vliw_fetch_pc: directed and randomized checks of the bundle PC against a behavioural model
module tb_vliw_fetch_pc;
   import vliw_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   vliw_fetch_pc_if #(.ADDR_W(32), .N_BR(4)) bus ();
   vliw_fetch_pc_if #(.ADDR_W(8), .N_BR(4)) bus8 ();
   vliw_fetch_pc dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   vliw_fetch_pc #(.ADDR_W(8), .RESET_VEC(8'hF4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   always #5 clk = ~clk;
   addr_t m_pc;
   int m_left;
   int m_src;
   bit m_mis;
   int m8;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic check_all(input string tag);
      check({tag, ".pc"}, bus.pc, m_pc);
      check({tag, ".squash"}, {31'd0, bus.squash}, {31'd0, m_left > 0});
      check({tag, ".misalign"}, {31'd0, bus.misalign}, {31'd0, m_mis});
      check({tag, ".src"}, {29'd0, bus.redirect_src}, m_src);
      check({tag, ".pc8"}, {24'd0, bus8.pc}, m8);
      check({tag, ".mis8"}, {31'd0, bus8.misalign}, 32'd0);
   endtask
   task automatic model_reset();
      m_pc = 32'h4; m_left = 0; m_src = 0; m_mis = 0; m8 = 'hF4;
   endtask
   // One clock: model applies the rules to the inputs held across the edge, then outputs are compared.
   task automatic step(input string tag);
      addr_t tgt;
      bit redir;
      int s;
      @(posedge clk);
      redir = 0; tgt = 0; s = 0;
      if (bus.trap) begin redir = 1; tgt = bus.trap_vec; s = 4; end
      else for (int i = 0; i < 4 && !redir; i++)
         if (bus.br_taken[i]) begin redir = 1; tgt = bus.br_target[i]; s = i; end
      if (redir) begin
         m_pc = (tgt / 16) * 16; m_mis = (tgt % 16) != 0; m_src = s; m_left = 2;
      end else begin
         m_mis = 0;
         if (!bus.stall) begin
            m_pc = m_pc + 16;
            if (m_left > 0) m_left--;
         end
      end
      m8 = (m8 + 16) % 256;
      @(negedge clk);
      check_all(tag);
   endtask
   task automatic idle();
      bus.stall = 0; bus.br_taken = '0; bus.trap = 0;
   endtask
   initial begin
      idle();
      bus.br_target = '0; bus.trap_vec = '0;
      bus8.stall = 0; bus8.br_taken = '0; bus8.br_target = '0; bus8.trap = 0; bus8.trap_vec = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      rst_n = 1;
      repeat (3) step("advance");
      check("advance.seq", bus.pc, 32'h34);
      check("wrap.seq", {24'd0, bus8.pc}, 32'h24);
      bus.br_taken = 4'b1010;
      bus.br_target[1] = 32'h200; bus.br_target[3] = 32'h300;
      step("multi_br");
      check("multi_br.target", bus.pc, 32'h200);
      idle();
      step("multi_br.sq1");
      step("multi_br.sq2");
      bus.br_taken = 4'b1010; bus.trap = 1; bus.trap_vec = 32'h800;
      step("trap_wins");
      check("trap_wins.src", {29'd0, bus.redirect_src}, 32'd4);
      idle();
      step("trap.after");
      bus.br_taken = 4'b0001; bus.br_target[0] = 32'h1234;
      step("misalign");
      check("misalign.pc", bus.pc, 32'h1230);
      idle();
      step("misalign.next");
      check("misalign.next.pc", bus.pc, 32'h1240);
      bus.stall = 1; bus.br_taken = 4'b0100; bus.br_target[2] = 32'h400;
      step("stall_redir");
      bus.br_taken = '0;
      repeat (3) step("stall_hold");
      check("stall_hold.pc", bus.pc, 32'h400);
      bus.stall = 0;
      step("stall_rel1");
      step("stall_rel2");
      check("stall_rel2.squash", {31'd0, bus.squash}, 32'd0);
      bus.br_taken = 4'b0010; bus.br_target[1] = 32'h500;
      step("reload.a");
      idle();
      step("reload.a1");
      bus.br_taken = 4'b1000; bus.br_target[3] = 32'h600;
      step("reload.b");
      idle();
      step("reload.b1");
      check("reload.b1.squash", {31'd0, bus.squash}, 32'd1);
      step("reload.b2");
      repeat (300) begin
         bus.stall = ($urandom % 4) == 0;
         bus.br_taken = (($urandom % 5) == 0) ? 4'($urandom) : 4'b0;
         bus.trap = ($urandom % 16) == 0;
         bus.trap_vec = $urandom;
         for (int i = 0; i < 4; i++) bus.br_target[i] = $urandom;
         step("rand");
      end
      idle();
      bus.br_taken = 4'b0001; bus.br_target[0] = 32'h700;
      step("mid_rst.redir");
      idle();
      #2 rst_n = 0;
      #1 model_reset();
      check("mid_rst.squash", {31'd0, bus.squash}, 32'd0);
      check("mid_rst.pc", bus.pc, 32'h4);
      check("mid_rst.pc8", {24'd0, bus8.pc}, 32'hF4);
      @(negedge clk);
      rst_n = 1;
      step("post_rst");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
